// File: rtl/uart_sample_sequencer.sv
// uart_sample_sequencer
// Builds 16-bit filter samples from pairs of received UART bytes (low byte
// first), hands each sample to the filter, and returns the signed filter result
// to the UART transmitter as five bytes, least significant byte first.
// Optional feature: define SEQ_RX_TIMEOUT_EN to abandon a half-received sample
// after TIMEOUT_CYCLES idle cycles waiting for its high byte.
module uart_sample_sequencer #(
  parameter int UART_BITS      = 8,
  parameter int INPUT_WIDTH    = 16,
  parameter int OUT_WIDTH      = 38,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_BITS-1:0]   rx_data,
  input  logic                   rx_valid,
  output logic [INPUT_WIDTH-1:0] filt_in,
  output logic                   filt_in_valid,
  input  logic [OUT_WIDTH-1:0]   filt_out,
  input  logic                   filt_out_valid,
  output logic [UART_BITS-1:0]   tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   overrun,
  output logic [15:0]            sample_count
);

  // The result is always sent as five bytes, so it is widened to 40 bits.
  localparam int TX_BYTES = 5;
  localparam int CAP_W    = TX_BYTES * UART_BITS;

  typedef enum logic [2:0] {
    RX_LO    = 3'd0,
    RX_HI    = 3'd1,
    FEED     = 3'd2,
    WAIT_RES = 3'd3,
    TX_SEND  = 3'd4,
    TX_GUARD = 3'd5,
    TX_WAIT  = 3'd6
  } state_t;

  state_t               state_r;
  logic [UART_BITS-1:0] lo_byte_r;
  logic [CAP_W-1:0]     cap_r;
  logic [2:0]           idx_r;
  logic                 rx_drop_s;
  logic                 tmo_hit_s;
  logic [CAP_W-1:0]     cap_ext_s;
  logic [UART_BITS-1:0] tx_byte_s;

  // Sign-extend the filter result to the full transmit width.
  always_comb begin
    cap_ext_s = {{(CAP_W-OUT_WIDTH){filt_out[OUT_WIDTH-1]}}, filt_out};
  end

  // Bytes arriving while a sample is in flight cannot be buffered and are dropped.
  always_comb begin
    rx_drop_s = 1'b0;
    case (state_r)
      RX_LO, RX_HI: rx_drop_s = 1'b0;
      default:      rx_drop_s = rx_valid;
    endcase
  end

  // Select the captured result byte addressed by the byte index.
  always_comb begin
    tx_byte_s = '0;
    case (idx_r)
      3'd0:    tx_byte_s = cap_r[1*UART_BITS-1:0*UART_BITS];
      3'd1:    tx_byte_s = cap_r[2*UART_BITS-1:1*UART_BITS];
      3'd2:    tx_byte_s = cap_r[3*UART_BITS-1:2*UART_BITS];
      3'd3:    tx_byte_s = cap_r[4*UART_BITS-1:3*UART_BITS];
      3'd4:    tx_byte_s = cap_r[5*UART_BITS-1:4*UART_BITS];
      default: tx_byte_s = '0;
    endcase
  end

`ifdef SEQ_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  // The timeout fires on the TIMEOUT_CYCLES-th consecutive idle cycle in RX_HI.
  always_comb begin
    if ((state_r == RX_HI) && !rx_valid && (tmo_cnt_r == TMO_LAST)) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Count idle cycles spent waiting for the high byte; cleared on any byte or exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == RX_HI) && !rx_valid && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end else begin
      tmo_cnt_r <= '0;
    end
  end
`else
  // Without the timeout feature RX_HI waits for its high byte forever.
  always_comb begin
    tmo_hit_s = 1'b0;
  end
`endif

  // Main sequencer: sample assembly, filter handshake and byte-wise transmission.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RX_LO;
      lo_byte_r     <= '0;
      cap_r         <= '0;
      idx_r         <= 3'd0;
      filt_in       <= '0;
      filt_in_valid <= 1'b0;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      overrun       <= 1'b0;
      sample_count  <= 16'd0;
    end else begin
      filt_in_valid <= 1'b0;
      tx_start      <= 1'b0;
      if (rx_drop_s) begin
        overrun <= 1'b1;
      end
      case (state_r)
        RX_LO: begin
          if (rx_valid) begin
            lo_byte_r <= rx_data;
            state_r   <= RX_HI;
          end
        end
        RX_HI: begin
          // filt_in only changes as a whole, so it stays stable between pulses.
          if (rx_valid) begin
            filt_in       <= {rx_data, lo_byte_r};
            filt_in_valid <= 1'b1;
            state_r       <= FEED;
          end else if (tmo_hit_s) begin
            lo_byte_r <= '0;
            state_r   <= RX_LO;
          end
        end
        FEED: begin
          // filt_in_valid is high during this cycle only.
          state_r <= WAIT_RES;
        end
        WAIT_RES: begin
          if (filt_out_valid) begin
            cap_r   <= cap_ext_s;
            idx_r   <= 3'd0;
            state_r <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!tx_busy) begin
            tx_data  <= tx_byte_s;
            tx_start <= 1'b1;
            state_r  <= TX_GUARD;
          end
        end
        TX_GUARD: begin
          // tx_busy only rises the cycle after tx_start, so skip one cycle.
          state_r <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!tx_busy) begin
            if (idx_r < 3'd4) begin
              idx_r   <= idx_r + 3'd1;
              state_r <= TX_SEND;
            end else begin
              sample_count <= sample_count + 16'd1;
              state_r      <= RX_LO;
            end
          end
        end
        default: begin
          state_r <= RX_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sample_sequencer.sv
// Directed self-checking bench for uart_sample_sequencer.
// Build with +define+SEQ_RX_TIMEOUT_EN to exercise the receive timeout.
module tb_uart_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] filt_in;
  logic        filt_in_valid;
  logic [37:0] filt_out = 38'h0;
  logic        filt_out_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        overrun;
  logic [15:0] sample_count;

  int errors = 0;
  int checks = 0;

  // Monitor state
  int          fiv_cnt = 0;
  logic [15:0] last_fin = 16'h0;
  logic [7:0]  txq[$];
  int          busy_viol = 0;
  int          both_viol = 0;
  int          wide_viol = 0;
  logic        fiv_prev = 1'b0;

  // Transmitter model
  int busy_len = 3;
  int busy_cnt = 0;

  uart_sample_sequencer #(
    .UART_BITS(8), .INPUT_WIDTH(16), .OUT_WIDTH(38), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .filt_in(filt_in), .filt_in_valid(filt_in_valid),
    .filt_out(filt_out), .filt_out_valid(filt_out_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .overrun(overrun), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for busy_len cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len - 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  // Record pulses and protocol violations on every rising edge.
  always @(posedge clk) begin
    fiv_prev <= filt_in_valid;
    if (filt_in_valid) begin
      fiv_cnt  <= fiv_cnt + 1;
      last_fin <= filt_in;
      if (fiv_prev) wide_viol <= wide_viol + 1;
    end
    if (tx_start) begin
      txq.push_back(tx_data);
      if (tx_busy) busy_viol <= busy_viol + 1;
      if (filt_in_valid) both_viol <= both_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_result(input logic [37:0] v);
    filt_out       = v;
    filt_out_valid = 1'b1;
    step();
    filt_out_valid = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] target, input int bound);
    int n = 0;
    while (sample_count !== target && n < bound) begin
      step();
      n++;
    end
    check("sample_count", 64'(sample_count), 64'(target));
  endtask

  task automatic wait_txq(input int size, input int bound);
    int n = 0;
    while (txq.size() < size && n < bound) begin
      step();
      n++;
    end
    check("txq_reached", 64'(txq.size()), 64'(size));
  endtask

  task automatic check_tx(input int base, input logic [39:0] exp);
    logic [39:0] e;
    e = exp;
    check("tx_byte_count", 64'(txq.size()), 64'(base + 5));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("tx_byte%0d", i), 64'(txq[base + i]), 64'(e[i*8 +: 8]));
    end
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    check("rst_filt_in", 64'(filt_in), 64'h0);
    check("rst_filt_in_valid", 64'(filt_in_valid), 64'h0);
    check("rst_tx_data", 64'(tx_data), 64'h0);
    check("rst_tx_start", 64'(tx_start), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    check("rst_sample_count", 64'(sample_count), 64'h0);

    // Two bytes form one sample, one filt_in_valid pulse
    send_byte(8'h34);
    step();
    step();
    check("fin_stable_mid", 64'(filt_in), 64'h0);
    send_byte(8'h12);
    repeat (4) step();
    check("fiv_count_1", 64'(fiv_cnt), 64'd1);
    check("fin_pulse_1234", 64'(last_fin), 64'h1234);
    check("fin_hold_1234", 64'(filt_in), 64'h1234);

    // Negative result, LSB byte first, sign extended to 40 bits
    base = txq.size();
    busy_len = 3;
    send_result(38'h20_0000_0001);
    wait_count(16'd1, 300);
    check_tx(base, 40'hE0_0000_0001);

    // filt_out_valid in RX_LO is ignored
    send_result(38'h00_0000_00AA);
    repeat (20) step();
    check("ignored_fov_tx", 64'(txq.size()), 64'(base + 5));

    // Long busy periods: no tx_start while busy, all five bytes still sent
    busy_len = 50;
    send_byte(8'h78);
    send_byte(8'h56);
    step();
    check("fin_5678", 64'(filt_in), 64'h5678);
    base = txq.size();
    send_result(38'h3F_FFFF_FFFE);
    wait_count(16'd2, 2000);
    check_tx(base, 40'hFF_FFFF_FFFE);
    check("no_start_while_busy", 64'(busy_viol), 64'd0);

    // Byte during TX_WAIT is dropped and overrun sticks
    send_byte(8'h01);
    send_byte(8'h00);
    step();
    base = txq.size();
    send_result(38'h00_0000_0005);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("busy_seen", 64'(tx_busy), 64'd1);
    send_byte(8'h99);
    check("overrun_set", 64'(overrun), 64'd1);
    check("fin_after_drop", 64'(filt_in), 64'h0001);
    wait_count(16'd3, 2000);
    check_tx(base, 40'h00_0000_0005);
    check("overrun_held", 64'(overrun), 64'd1);
    n = fiv_cnt;
    send_byte(8'hCD);
    send_byte(8'hAB);
    step();
    check("fin_abcd", 64'(filt_in), 64'hABCD);
    check("fiv_after_drop", 64'(fiv_cnt), 64'(n + 1));
    check("overrun_still", 64'(overrun), 64'd1);

    // Reset during the third transmitted byte
    busy_len = 5;
    base = txq.size();
    send_result(38'h01_0203_0405);
    wait_txq(base + 3, 200);
    rst = 1'b1;
    step();
    check("mid_rst_filt_in", 64'(filt_in), 64'h0);
    check("mid_rst_fiv", 64'(filt_in_valid), 64'h0);
    check("mid_rst_tx_data", 64'(tx_data), 64'h0);
    check("mid_rst_tx_start", 64'(tx_start), 64'h0);
    check("mid_rst_overrun", 64'(overrun), 64'h0);
    check("mid_rst_count", 64'(sample_count), 64'h0);
    rst = 1'b0;
    repeat (20) step();
    check("no_tx_after_rst", 64'(txq.size()), 64'(base + 3));
    send_byte(8'h11);
    send_byte(8'h22);
    step();
    check("fin_after_rst", 64'(filt_in), 64'h2211);
    check("overrun_after_rst", 64'(overrun), 64'd0);

    // Feed the pending sample a result so the FSM returns to RX_LO
    send_result(38'h00_0000_0000);
    wait_count(16'd1, 300);

`ifdef SEQ_RX_TIMEOUT_EN
    // Low byte abandoned after 1000 idle cycles
    send_byte(8'hAA);
    repeat (1000) step();
    send_byte(8'h34);
    send_byte(8'h12);
    step();
    check("timeout_fin", 64'(filt_in), 64'h1234);
`else
    // Without the timeout, RX_HI waits indefinitely for the high byte
    n = fiv_cnt;
    send_byte(8'hAA);
    repeat (1100) step();
    check("no_timeout_fiv", 64'(fiv_cnt), 64'(n));
    send_byte(8'h12);
    step();
    check("no_timeout_fin", 64'(filt_in), 64'h12AA);
`endif

    check("start_and_fiv_apart", 64'(both_viol), 64'd0);
    check("fiv_one_cycle", 64'(wide_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
